// File: rtl/if_id_skid_stage_pkg.sv
// Shared IF/ID definitions: NOP encoding, ctrl hold/flush codes and stage state encoding.
// Also used by ctrl and ID so that all three agree on the hold codes.
package if_id_skid_stage_pkg;

   localparam logic [31:0] INST_NOP   = 32'h0000_0013;
   localparam logic [1:0]  HOLD_NONE  = 2'b00;
   localparam logic [1:0]  HOLD_FLUSH = 2'b01;
   localparam logic [1:0]  HOLD_PIPE  = 2'b10;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } state_e;

   // Codes 01 and 11 both flush, so bit 0 alone identifies a flush.
   function automatic logic is_flush(input logic [1:0] code);
      return code[0];
   endfunction

endpackage

// File: rtl/if_id_skid_stage_entry.sv
// One IF/ID payload register (address, instruction, prediction, fault, valid).
// Clear wins over load; with neither asserted the entry holds its contents.
module if_id_entry #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [INST_W-1:0] inst_i,
   input  logic              pred_i,
   input  logic              exc_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [INST_W-1:0] inst_o,
   output logic              pred_o,
   output logic              exc_o
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [INST_W-1:0] inst_q,  inst_d;
   logic              pred_q,  pred_d;
   logic              exc_q,   exc_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      pred_d  = pred_q;
      exc_d   = exc_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         addr_d  = addr_i;
         inst_d  = inst_i;
         pred_d  = pred_i;
         exc_d   = exc_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         inst_q  <= '0;
         pred_q  <= 1'b0;
         exc_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         pred_q  <= pred_d;
         exc_q   <= exc_d;
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign inst_o  = inst_q;
   assign pred_o  = pred_q;
   assign exc_o   = exc_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// ctrl hold/flush handling and NOP presentation when no beat is held.
module if_id_skid_stage
   import if_id_skid_stage_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = INST_NOP,
   parameter bit                SKID_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        hold_flag_i,
   input  logic              if_valid_i,
   output logic              if_ready_o,
   input  logic [ADDR_W-1:0] inst_addr_i,
   input  logic [INST_W-1:0] inst_i,
   input  logic              pred_taken_i,
   input  logic              fetch_exc_i,
   output logic              id_valid_o,
   input  logic              id_ready_i,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic [INST_W-1:0] inst_o,
   output logic              pred_taken_o,
   output logic              fetch_exc_o
);

   state_e state_q, state_d;

   logic              main_valid, main_pred, main_exc;
   logic [ADDR_W-1:0] main_addr;
   logic [INST_W-1:0] main_inst;
   logic              skid_valid, skid_pred, skid_exc;
   logic [ADDR_W-1:0] skid_addr;
   logic [INST_W-1:0] skid_inst;

   logic              flush, hold, out_raw, out_xfer, in_xfer;
   logic              main_load, main_from_skid, main_clear, skid_load, skid_clear;
   logic [ADDR_W-1:0] main_addr_in;
   logic [INST_W-1:0] main_inst_in;
   logic              main_pred_in, main_exc_in;

   assign flush    = is_flush(hold_flag_i);
   assign hold     = (hold_flag_i == HOLD_PIPE);
   assign out_raw  = main_valid & id_ready_i & ~hold;
   // A flush cancels both handshakes in the same cycle.
   assign out_xfer = out_raw & ~flush;
   assign in_xfer  = if_valid_i & if_ready_o & ~flush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (in_xfer) state_d = ST_ONE;
            ST_ONE: begin
               if (in_xfer && !out_xfer && SKID_EN) begin
                  state_d = ST_TWO;
               end else if (!in_xfer && out_xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO:   if (out_xfer) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      main_clear     = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: main_load = in_xfer;
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_load = 1'b1;
               end else if (in_xfer) begin
                  skid_load = SKID_EN;
               end else if (out_xfer) begin
                  main_clear = 1'b1;
               end
            end
            ST_TWO: begin
               if (out_xfer) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clear     = 1'b1;
               end
            end
            default: begin
               main_clear = 1'b1;
               skid_clear = 1'b1;
            end
         endcase
      end
   end

   assign main_addr_in = main_from_skid ? skid_addr : inst_addr_i;
   assign main_inst_in = main_from_skid ? skid_inst : inst_i;
   assign main_pred_in = main_from_skid ? skid_pred : pred_taken_i;
   assign main_exc_in  = main_from_skid ? skid_exc  : fetch_exc_i;

   if_id_entry #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_main (
      .clk     (clk),
      .rst     (rst),
      .clear_i (main_clear),
      .load_i  (main_load),
      .addr_i  (main_addr_in),
      .inst_i  (main_inst_in),
      .pred_i  (main_pred_in),
      .exc_i   (main_exc_in),
      .valid_o (main_valid),
      .addr_o  (main_addr),
      .inst_o  (main_inst),
      .pred_o  (main_pred),
      .exc_o   (main_exc)
   );

   generate
      if (SKID_EN) begin : g_skid
         if_id_entry #(
            .ADDR_W (ADDR_W),
            .INST_W (INST_W)
         ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .clear_i (skid_clear),
            .load_i  (skid_load),
            .addr_i  (inst_addr_i),
            .inst_i  (inst_i),
            .pred_i  (pred_taken_i),
            .exc_i   (fetch_exc_i),
            .valid_o (skid_valid),
            .addr_o  (skid_addr),
            .inst_o  (skid_inst),
            .pred_o  (skid_pred),
            .exc_o   (skid_exc)
         );
         // Ready comes straight from a flop, so ID's ready never reaches IF.
         assign if_ready_o = ~skid_valid;
      end else begin : g_no_skid
         assign skid_valid = 1'b0;
         assign skid_addr  = '0;
         assign skid_inst  = '0;
         assign skid_pred  = 1'b0;
         assign skid_exc   = 1'b0;
         assign if_ready_o = ~main_valid | out_raw;
      end
   endgenerate

   assign id_valid_o   = main_valid;
   assign inst_addr_o  = main_valid ? main_addr : '0;
   assign inst_o       = main_valid ? main_inst : NOP_INST;
   assign pred_taken_o = main_valid & main_pred;
   assign fetch_exc_o  = main_valid & main_exc;

endmodule

// File: tb/tb_if_id_skid_stage.sv
module tb_if_id_skid_stage;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] inst;
      logic        pred;
      logic        exc;
   } beat_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  hold_flag;
   logic        if_valid;
   logic [63:0] inst_addr;
   logic [31:0] inst;
   logic        pred_taken;
   logic        fetch_exc;
   logic        id_ready;

   logic        if_ready_a [2];
   logic        id_valid_a [2];
   logic [63:0] addr_a     [2];
   logic [31:0] inst_a     [2];
   logic        pred_a     [2];
   logic        exc_a      [2];
   beat_t       obs        [2];

   int    total = 0;
   int    bad   = 0;
   int    cnt [2];
   int    rd  [2];
   int    wr  [2];
   beat_t sb  [2][64];
   bit    exp_in  [2];
   bit    exp_out [2];

   always #5 clk = ~clk;

   if_id_skid_stage #(.ADDR_W(64), .INST_W(32), .NOP_INST(NOP), .SKID_EN(1'b0)) u_noskid (
      .clk(clk), .rst(rst), .hold_flag_i(hold_flag), .if_valid_i(if_valid),
      .if_ready_o(if_ready_a[0]), .inst_addr_i(inst_addr), .inst_i(inst),
      .pred_taken_i(pred_taken), .fetch_exc_i(fetch_exc), .id_valid_o(id_valid_a[0]),
      .id_ready_i(id_ready), .inst_addr_o(addr_a[0]), .inst_o(inst_a[0]),
      .pred_taken_o(pred_a[0]), .fetch_exc_o(exc_a[0])
   );

   if_id_skid_stage #(.ADDR_W(64), .INST_W(32), .NOP_INST(NOP), .SKID_EN(1'b1)) u_skid (
      .clk(clk), .rst(rst), .hold_flag_i(hold_flag), .if_valid_i(if_valid),
      .if_ready_o(if_ready_a[1]), .inst_addr_i(inst_addr), .inst_i(inst),
      .pred_taken_i(pred_taken), .fetch_exc_i(fetch_exc), .id_valid_o(id_valid_a[1]),
      .id_ready_i(id_ready), .inst_addr_o(addr_a[1]), .inst_o(inst_a[1]),
      .pred_taken_o(pred_a[1]), .fetch_exc_o(exc_a[1])
   );

   assign obs[0] = {addr_a[0], inst_a[0], pred_a[0], exc_a[0]};
   assign obs[1] = {addr_a[1], inst_a[1], pred_a[1], exc_a[1]};

   `define CHK(tag, o, e) \
      begin \
         total++; \
         assert ((o) === (e)) else begin \
            bad++; \
            $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, k, $time, o, e); \
         end \
      end

   task automatic check_dut(input int k);
      bit    ev, orw, er;
      beat_t eb;
      ev  = cnt[k] > 0;
      orw = ev && id_ready && (hold_flag != 2'b10);
      er  = (k == 1) ? (cnt[k] < 2) : (!ev || orw);
      eb  = ev ? sb[k][rd[k] & 63] : {64'h0, NOP, 1'b0, 1'b0};
      `CHK("id_valid", id_valid_a[k], ev)
      `CHK("if_ready", if_ready_a[k], er)
      `CHK("payload", obs[k], eb)
      exp_in[k]  = if_valid && er;
      exp_out[k] = orw;
   endtask

   task automatic check_reset_state(input int k);
      total++;
      if (id_valid_a[k] !== 1'b0 || inst_a[k] !== NOP || addr_a[k] !== 64'h0 ||
          pred_a[k] !== 1'b0 || exc_a[k] !== 1'b0 || if_ready_a[k] !== 1'b1) begin
         bad++;
         $error("FAIL reset_state dut%0d t=%0t v=%0d inst=%0h addr=%0h pred=%0d exc=%0d rdy=%0d",
                k, $time, id_valid_a[k], inst_a[k], addr_a[k], pred_a[k], exc_a[k], if_ready_a[k]);
      end else begin
         $display("reset dut%0d: v=%0d inst=%0h addr=%0h rdy=%0d", k, id_valid_a[k], inst_a[k],
                  addr_a[k], if_ready_a[k]);
      end
   endtask

   task automatic update_dut(input int k);
      if (!rst || hold_flag[0]) begin
         cnt[k] = 0;
         rd[k]  = 0;
         wr[k]  = 0;
      end else begin
         if (exp_out[k]) begin
            rd[k]++;
            cnt[k]--;
         end
         if (exp_in[k]) begin
            sb[k][wr[k] & 63] = {inst_addr, inst, pred_taken, fetch_exc};
            wr[k]++;
            cnt[k]++;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      for (int k = 0; k < 2; k++) check_dut(k);
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) update_dut(k);
   endtask

   task automatic drive(input bit v, input logic [63:0] a, input bit r, input logic [1:0] h);
      if_valid   = v;
      inst_addr  = a;
      inst       = a[31:0] + 32'hA000_0000;
      pred_taken = a[2];
      fetch_exc  = a[3];
      id_ready   = r;
      hold_flag  = h;
      cycle();
      $display("step v=%0d addr=%0h rdy=%0d hold=%b | skid: v=%0d rdy=%0d a=%0h | noskid: v=%0d rdy=%0d a=%0h",
               v, a, r, h, id_valid_a[1], if_ready_a[1], addr_a[1], id_valid_a[0], if_ready_a[0], addr_a[0]);
   endtask

   initial begin
      #200000;
      $error("FAIL timeout: simulation did not finish t=%0t", $time);
      $finish;
   end

   initial begin
      rst = 1'b0;
      if_valid = 1'b1; inst_addr = 64'h1234; inst = 32'hDEAD_BEEF; pred_taken = 1'b1; fetch_exc = 1'b1;
      id_ready = 1'b1; hold_flag = 2'b00;
      for (int k = 0; k < 2; k++) begin
         cnt[k] = 0; rd[k] = 0; wr[k] = 0; exp_in[k] = 0; exp_out[k] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) check_reset_state(k);
      rst = 1'b1;

      drive(0, 64'h0, 1, 2'b00);

      drive(1, 64'h1000, 1, 2'b00);
      drive(1, 64'h1004, 1, 2'b00);
      drive(1, 64'h1008, 1, 2'b00);
      drive(0, 64'h0, 1, 2'b00);
      drive(0, 64'h0, 1, 2'b00);

      drive(1, 64'h2000, 0, 2'b00);
      drive(1, 64'h2004, 0, 2'b00);
      drive(0, 64'h0, 0, 2'b00);

      drive(0, 64'h0, 1, 2'b10);
      drive(0, 64'h0, 1, 2'b10);
      drive(0, 64'h0, 1, 2'b10);

      drive(0, 64'h0, 1, 2'b00);
      drive(0, 64'h0, 1, 2'b00);
      drive(0, 64'h0, 1, 2'b00);

      drive(1, 64'h2008, 0, 2'b00);
      drive(1, 64'h200C, 0, 2'b00);
      drive(1, 64'h3000, 1, 2'b01);
      drive(0, 64'h0, 1, 2'b00);

      drive(1, 64'h2010, 0, 2'b00);
      drive(1, 64'h2014, 0, 2'b00);
      drive(1, 64'h3000, 1, 2'b11);
      drive(0, 64'h0, 1, 2'b00);

      drive(1, 64'h2018, 0, 2'b00);
      drive(1, 64'h3004, 1, 2'b01);
      drive(0, 64'h0, 1, 2'b00);

      drive(1, 64'h4000, 1, 2'b00);
      drive(1, 64'h4004, 0, 2'b00);
      drive(1, 64'h4008, 1, 2'b00);
      drive(1, 64'h400C, 1, 2'b00);
      drive(1, 64'h4010, 0, 2'b00);
      drive(1, 64'h4014, 1, 2'b00);
      drive(0, 64'h0, 1, 2'b00);
      drive(0, 64'h0, 1, 2'b00);
      drive(0, 64'h0, 1, 2'b00);

      drive(1, 64'h5000, 0, 2'b00);
      drive(1, 64'h5004, 0, 2'b00);
      rst = 1'b0;
      drive(1, 64'h5008, 1, 2'b00);
      rst = 1'b1;
      drive(0, 64'h0, 1, 2'b00);

      for (int i = 0; i < 300; i++) begin
         int unsigned r;
         logic [1:0]  h;
         r = $urandom_range(0, 15);
         h = (r == 0) ? 2'b01 : (r == 1) ? 2'b11 : (r < 4) ? 2'b10 : 2'b00;
         drive(1'($urandom_range(0, 1)), 64'h6000 + 64'(i * 4), ($urandom_range(0, 3) != 0), h);
      end

      for (int i = 0; i < 4; i++) drive(0, 64'h0, 1, 2'b00);

      if (bad != 0) begin
         $error("FAIL summary: %0d of %0d checks failed", bad, total);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
Parametrised IF→ID pipeline stage with a valid/ready handshake and an optional 2-entry skid buffer. It carries the fetch address, instruction, branch-prediction bit and fetch-fault flag. It honours the ctrl hold/flush code and presents the NOP instruction whenever it holds no valid beat. It sits between the fetch unit and the decoder, and removes the combinational ready path from ID back to IF.

Parameters:
ADDR_W, 64, instruction address width
INST_W, 32, instruction width
NOP_INST, 32'h0000_0013, instruction driven when no valid beat is held (addi x0,x0,0)
SKID_EN, 1, 1 = 2-entry skid buffer with registered if_ready_o; 0 = single entry with combinational ready

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-low reset
hold_flag_i  input  2  ctrl code: 00 none, 01 flush, 10 hold, 11 flush
if_valid_i  input  1  fetch beat valid
if_ready_o  output  1  stage can accept a beat
inst_addr_i  input  ADDR_W  fetch address
inst_i  input  INST_W  fetched instruction
pred_taken_i  input  1  predictor taken bit
fetch_exc_i  input  1  fetch access fault
id_valid_o  output  1  beat valid to ID
id_ready_i  input  1  ID accepts the beat
inst_addr_o  output  ADDR_W  address to ID
inst_o  output  INST_W  instruction to ID
pred_taken_o  output  1  predictor bit to ID
fetch_exc_o  output  1  fault flag to ID

Behaviour:
- Reset (rst==0 at a clk edge): both entries invalid; id_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, pred_taken_o=0, fetch_exc_o=0, if_ready_o=1.
- Input transfer: in = if_valid_i & if_ready_o.
- Output transfer: out = id_valid_o & id_ready_i & (hold_flag_i != 2'b10). Hold acts as downstream stall; outputs stay stable while held.
- Outputs are driven from the main entry only. While main is invalid, data outputs are forced to NOP_INST/0/0/0.
- Latency: a beat accepted at edge N is visible on outputs after edge N (1 cycle).
- States (SKID_EN=1), next state as follows:
  - EMPTY: in → ONE (main←in).
  - ONE: in&out → ONE (main←in); in&!out → TWO (skid←in); !in&out → EMPTY; otherwise stay.
  - TWO: out → ONE (main←skid); otherwise stay. No input is accepted in TWO.
- if_ready_o (SKID_EN=1) = !skid_valid, registered. There is no combinational path from id_ready_i or hold_flag_i.
- SKID_EN=0: TWO is unreachable. if_ready_o = !main_valid | out (combinational). in&out replaces main in the same edge.
- Flush (hold_flag_i==01 or 11) has priority over hold, in and out:
  - Next edge: all entries invalid, state EMPTY, outputs return to NOP/0.
  - A beat presented in the flush cycle is dropped even if if_ready_o=1.
  - The beat currently on the outputs is not considered transferred, even if id_ready_i=1.
- Ordering: beats leave in acceptance order; no duplication, no loss except by flush.
- Reset mid-operation behaves identically to flush and also clears the registered ready to 1.
- id_valid_o never drops without an output transfer, flush or reset. Data is stable while id_valid_o=1 & !out.

Decomposition:
- defines.v gains the following, used by ctrl, this stage and ID:
  - INST_NOP (= NOP_INST default)
  - HOLD_NONE=2'b00, HOLD_FLUSH=2'b01, HOLD_PIPE=2'b10
- Sub-module if_id_entry: one payload register (addr, inst, pred, exc, valid) with load, clear and hold. It is instantiated twice (main, skid); skid is generated only when SKID_EN=1.
- Top module holds the state decode, ready generation and flush priority.

Test Plan:
- Reset: rst=0 for 2 cycles with if_valid_i=1 → id_valid_o=0, inst_o=32'h0000_0013, inst_addr_o=0, if_ready_o=1.
- Streaming: id_ready_i=1, beats at addresses 0x1000,0x1004,0x1008 on consecutive cycles → each appears 1 cycle later, back-to-back, id_valid_o=1 for 3 cycles.
- Backpressure: id_ready_i=0 while 0x2000 and 0x2004 arrive → state TWO and if_ready_o=0 the next cycle. Release ready → 0x2000 then 0x2004 delivered in order, if_ready_o=1 again.
- Hold: state TWO, hold_flag_i=10 with id_ready_i=1 for 3 cycles → outputs frozen at 0x2000 with no transfer; hold=00 → drain resumes.
- Flush: state TWO plus incoming 0x3000 with hold_flag_i=01 → next cycle id_valid_o=0, inst_o=NOP, if_ready_o=1, and 0x3000 is never output. Repeat with code 11 → same result.
- SKID_EN=0 build: id_ready_i toggling 1,0,1 with continuous input → if_ready_o follows out combinationally, no beat lost, order preserved, no skid state observed.
